// File: rtl/alu_pkg.sv
// Shared ALU definitions: mode codes, op and state encodings,
// and the N/Z flag helper used by the sequencer.
package alu_pkg;

  localparam logic [4:0] MODE_ADC = 5'b00001;
  localparam logic [4:0] MODE_AND = 5'b00101;
  localparam logic [4:0] MODE_ORA = 5'b00110;
  localparam logic [4:0] MODE_EOR = 5'b00111;
  localparam logic [4:0] MODE_SRS = 5'b01000;

  typedef enum logic [3:0] {
    ADC = 4'd0,
    SBC = 4'd1,
    AND = 4'd2,
    ORA = 4'd3,
    EOR = 4'd4,
    CMP = 4'd5,
    ASL = 4'd6,
    ROL = 4'd7,
    SEC = 4'd8,
    CLC = 4'd9,
    CLV = 4'd10
  } op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WB    = 2'd2
  } state_t;

  // {N, Z} for an 8-bit result
  function automatic logic [1:0] nz(input logic [7:0] v);
    return {v[7], (v == 8'h00)};
  endfunction

endpackage

// File: rtl/alu_sequencer.sv
// Execution-side controller: issues ops to the 6502 ALU and
// commits results into the accumulator and N/Z/C/V flags.
module alu_sequencer
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [3:0] req_op,
  input  logic [7:0] req_operand,
  input  logic       load_valid,
  input  logic [7:0] load_data,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [4:0] alu_mode,
  output logic       alu_carry_in,
  input  logic [7:0] alu_result,
  input  logic       alu_carry_out,
  input  logic       alu_overflow,
  output logic [7:0] acc,
  output logic       flag_n,
  output logic       flag_z,
  output logic       flag_c,
  output logic       flag_v,
  output logic       done
);

  state_t     r_state;
  op_t        r_op;
  logic [7:0] r_acc;
  logic       r_n;
  logic       r_z;
  logic       r_c;
  logic       r_v;
  logic       r_done;
  logic [7:0] r_alu_a;
  logic [7:0] r_alu_b;
  logic [4:0] r_alu_mode;
  logic       r_alu_cin;

  op_t        w_op;
  logic [7:0] w_b;
  logic [4:0] w_mode;
  logic       w_cin;
  logic       w_flag_op;

  assign w_op = op_t'(req_op);

  // Operand B / mode / carry-in for the op being offered
  always_comb begin
    w_b       = req_operand;
    w_mode    = MODE_ADC;
    w_cin     = 1'b0;
    w_flag_op = 1'b0;
    case (w_op)
      ADC: w_cin = r_c;
      SBC: begin
        w_b   = ~req_operand;
        w_cin = r_c;
      end
      AND: w_mode = MODE_AND;
      ORA: w_mode = MODE_ORA;
      EOR: w_mode = MODE_EOR;
      CMP: begin
        w_b   = ~req_operand;
        w_cin = 1'b1;
      end
      ASL: w_b = r_acc;
      ROL: begin
        w_b   = r_acc;
        w_cin = r_c;
      end
      SEC, CLC, CLV: w_flag_op = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_op       <= ADC;
      r_acc      <= 8'h00;
      r_n        <= 1'b0;
      r_z        <= 1'b0;
      r_c        <= 1'b0;
      r_v        <= 1'b0;
      r_done     <= 1'b0;
      r_alu_a    <= 8'h00;
      r_alu_b    <= 8'h00;
      r_alu_mode <= MODE_ADC;
      r_alu_cin  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_op <= w_op;
            if (w_flag_op) begin
              r_state <= WB;
            end else begin
              r_state    <= ISSUE;
              r_alu_a    <= r_acc;
              r_alu_b    <= w_b;
              r_alu_mode <= w_mode;
              r_alu_cin  <= w_cin;
            end
          end else if (load_valid) begin
            r_acc        <= load_data;
            {r_n, r_z}   <= nz(load_data);
          end
        end
        ISSUE: r_state <= WB;
        WB: begin
          r_state <= IDLE;
          r_done  <= 1'b1;
          case (r_op)
            ADC, SBC: begin
              r_acc      <= alu_result;
              {r_n, r_z} <= nz(alu_result);
              r_c        <= alu_carry_out;
              r_v        <= alu_overflow;
            end
            AND, ORA, EOR: begin
              r_acc      <= alu_result;
              {r_n, r_z} <= nz(alu_result);
            end
            CMP: begin
              {r_n, r_z} <= nz(alu_result);
              r_c        <= alu_carry_out;
            end
            ASL, ROL: begin
              r_acc      <= alu_result;
              {r_n, r_z} <= nz(alu_result);
              r_c        <= alu_carry_out;
            end
            SEC: r_c <= 1'b1;
            CLC: r_c <= 1'b0;
            CLV: r_v <= 1'b0;
            default: ;
          endcase
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready    = (r_state == IDLE);
  assign alu_a        = r_alu_a;
  assign alu_b        = r_alu_b;
  assign alu_mode     = r_alu_mode;
  assign alu_carry_in = r_alu_cin;
  assign acc          = r_acc;
  assign flag_n       = r_n;
  assign flag_z       = r_z;
  assign flag_c       = r_c;
  assign flag_v       = r_v;
  assign done         = r_done;

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Execution-side controller that drives the 6502-style ALU and consumes its results.
- Accepts arithmetic/logic ops over a valid/ready handshake.
- Registers the ALU operands, mode and carry_in, then captures alu_out, carry_out and overflow.
- Owns the accumulator and the N/Z/C/V status flags; sits between instruction decode and the ALU in the NES CPU core.

Parameters:
- None. Width is fixed at 8 bits.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  1  op request present
- req_ready  out  1  block can accept a request (high only in IDLE)
- req_op  in  4  operation, op_t from alu_pkg
- req_operand  in  8  memory/immediate operand
- load_valid  in  1  load accumulator directly
- load_data  in  8  value for load
- alu_a  out  8  ALU operand A (registered)
- alu_b  out  8  ALU operand B (registered)
- alu_mode  out  5  ALU mode (registered)
- alu_carry_in  out  1  ALU carry in (registered)
- alu_result  in  8  ALU alu_out
- alu_carry_out  in  1  ALU carry out
- alu_overflow  in  1  ALU signed overflow
- acc  out  8  accumulator
- flag_n, flag_z, flag_c, flag_v  out  1 each  status flags
- done  out  1  one-cycle pulse when an accepted op has committed

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: acc=0x00, all flags 0, done=0, alu_a=alu_b=0x00, alu_mode=MODE_ADC, alu_carry_in=0, state IDLE.
- States:
  - IDLE: req_ready=1.
  - ISSUE: the ALU settles on the registered inputs.
  - WB: commit acc/flags, done=1.
  - WB always returns to IDLE.
- Transitions and latency:
  - Accept = req_valid && req_ready.
  - ALU ops: IDLE -> ISSUE -> WB -> IDLE. done is high 2 cycles after the accept edge. Throughput is 1 op per 3 cycles.
  - SEC/CLC/CLV: IDLE -> WB -> IDLE. done is high 1 cycle after accept. ALU registers are untouched.
- Operand setup on accept (ALU registers hold their value until the next ALU-op accept):
  - ADC: a=acc, b=operand, mode ADC, cin=C.
  - SBC: a=acc, b=~operand, mode ADC, cin=C.
  - AND/ORA/EOR: a=acc, b=operand, matching mode, cin=0.
  - CMP: a=acc, b=~operand, mode ADC, cin=1.
  - ASL: a=acc, b=acc, mode ADC, cin=0. Operand is ignored.
  - ROL: a=acc, b=acc, mode ADC, cin=C. Operand is ignored.
- Commit in WB (r = alu_result sampled in WB):
  - ADC/SBC: acc=r. N=r[7], Z=(r==0), C=alu_carry_out, V=alu_overflow.
  - AND/ORA/EOR: acc=r. N and Z updated; C and V unchanged.
  - CMP: acc unchanged. N, Z and C updated (C=1 means acc>=operand, unsigned); V unchanged.
  - ASL/ROL: acc=r. N, Z updated; C=alu_carry_out (the old acc[7]); V unchanged.
  - SEC: C=1. CLC: C=0. CLV: V=0.
  - Reserved op codes (11-15): ALU path, no acc/flag change, done still pulses.
- Load:
  - Honoured only in IDLE with req_valid=0: acc=load_data, N and Z updated, the next cycle stays IDLE, no done.
  - load_valid in ISSUE/WB, or together with req_valid in IDLE: load is dropped (request wins).
- Boundaries:
  - req_operand and req_op are sampled only on the accept edge. Changes while req_ready=0 have no effect.
  - reset in any state, including mid-op: next cycle IDLE with reset values. No done for the aborted op.
  - Wrap-around is plain 8-bit modulo arithmetic; the carry is carried only in C.

Decomposition:
- Package alu_pkg holds:
  - mode constants (5-bit): MODE_ADC=5'b00001, MODE_AND=5'b00101, MODE_ORA=5'b00110, MODE_EOR=5'b00111, MODE_SRS=5'b01000.
  - op_t enum: ADC=0, SBC=1, AND=2, ORA=3, EOR=4, CMP=5, ASL=6, ROL=7, SEC=8, CLC=9, CLV=10.
  - state_t enum: IDLE, ISSUE, WB.
- The ALU itself imports the same package.
- No sub-module is needed. The N/Z derivation is a single function in alu_pkg.
- The bench pairs this block with the ALU or a behavioural ALU model that has correct two's-complement overflow.

Test Plan:
1. load 0x50, CLC, ADC 0x50 -> acc=0xA0, N=1, Z=0, C=0, V=1. done exactly 2 cycles after accept; req_ready low for those 2 cycles.
2. load 0x05, SEC, SBC 0x06 -> acc=0xFF, N=1, C=0, V=0. SEC done 1 cycle after accept.
3. load 0x40, CMP 0x40 -> Z=1, C=1, N=0, acc stays 0x40, V unchanged. Then CMP 0x41 -> C=0, N=1.
4. load 0x81, SEC, ROL -> acc=0x03, C=1, N=0. Then load 0x80, ASL -> acc=0x00, Z=1, C=1.
5. Hold req_valid=1 for 9 cycles with req_operand changing every cycle -> exactly 3 accepts. Each accept uses the operand present on its accept edge. load_valid asserted during ISSUE is dropped.
6. Accept ADC, assert reset in ISSUE -> next cycle IDLE, acc=0x00, flags 0, alu_* at reset values, no done pulse.
